// File: rtl/psram_bd_pkg.sv
// Shared definitions for the PSRAM bd_* responder: command codes, FSM states,
// mode-register defaults and the byte-mask merge helper.
package psram_bd_pkg;

    localparam logic [7:0] CMD_INIT = 8'h00;
    localparam logic [7:0] CMD_GRST = 8'h80;
    localparam logic [7:0] CMD_MRW  = 8'h01;
    localparam logic [7:0] CMD_MRR  = 8'h02;
    localparam logic [7:0] CMD_AWR  = 8'h04;
    localparam logic [7:0] CMD_ARD  = 8'h08;

    localparam int MR_COUNT = 4;
    localparam logic [MR_COUNT-1:0][15:0] MR_DEFAULTS =
        {16'h0000, 16'h0000, 16'h0000, 16'h0001};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_RD_LAT   = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_INIT_CLR = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // A set mask bit keeps the old byte.
    function automatic logic [15:0] mask_merge(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [1:0]  mask);
        mask_merge = {mask[1] ? old_w[15:8] : new_w[15:8],
                      mask[0] ? old_w[7:0]  : new_w[7:0]};
    endfunction

endpackage

// File: rtl/psram_bd_mem.sv
// Single-port synchronous word RAM with two byte-write lanes; read data
// appears one cycle after the address. Contents are not reset.
module psram_bd_mem #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [1:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    // Byte-lane writes and registered read of the same address.
    always_ff @(posedge clk) begin
        if (we && be[1]) begin
            mem_q[addr][15:8] <= wdata[15:8];
        end
        if (we && be[0]) begin
            mem_q[addr][7:0] <= wdata[7:0];
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/psram_bd_responder.sv
// PSRAM-side responder: accepts one bd_* instruction at a time and runs array
// and mode-register accesses, INIT and global reset against on-chip storage.
module psram_bd_responder
    import psram_bd_pkg::*;
#(
    parameter int MEM_LEN    = 9,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bd_instruction_req,
    input  logic [7:0]         bd_command,
    input  logic [31:0]        bd_address,
    input  logic [MEM_LEN-1:0] bd_data_len,
    input  logic [15:0]        bd_wdata,
    input  logic [1:0]         bd_wdata_mask,
    output logic               bd_instruction_ready,
    output logic               bd_wdata_ready,
    output logic               bd_rdata_valid,
    output logic [15:0]        bd_rdata,
    output logic               busy,
    output logic               cmd_error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = MEM_LEN + 1;
    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    state_e                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [LAT_W-1:0]             lat_q, lat_d;
    logic                         is_mr_q, is_mr_d;
    logic                         ready_q, ready_d;
    logic                         cmd_error_q, cmd_error_d;
    logic [MR_COUNT-1:0][15:0]    mr_q, mr_d;
    logic [15:0]                  mr_rd_q, mr_rd_d;

    logic                         mem_we_s;
    logic [1:0]                   mem_be_s;
    logic [15:0]                  mem_wdata_s;
    logic [15:0]                  mem_rdata_s;
    logic                         unused_addr_s;

    assign unused_addr_s = ^bd_address[31:ADDR_WIDTH];

    psram_bd_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .be    (mem_be_s),
        .addr  (addr_q),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Next-state, counters, MR file updates and RAM port control.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        is_mr_d     = is_mr_q;
        ready_d     = 1'b0;
        cmd_error_d = 1'b0;
        mr_d        = mr_q;
        mr_rd_d     = mr_rd_q;
        mem_we_s    = 1'b0;
        mem_be_s    = 2'b00;
        mem_wdata_s = bd_wdata;

        case (state_q)
            ST_IDLE: begin
                if (bd_instruction_req) begin
                    ready_d = 1'b1;
                    addr_d  = bd_address[ADDR_WIDTH-1:0];
                    cnt_d   = {1'b0, bd_data_len} + CNT_W'(1);
                    lat_d   = '0;
                    is_mr_d = 1'b0;
                    case (bd_command)
                        CMD_AWR: state_d = ST_WR_DATA;
                        CMD_MRW: begin
                            state_d = ST_WR_DATA;
                            cnt_d   = CNT_W'(1);
                            is_mr_d = 1'b1;
                        end
                        CMD_ARD: state_d = ST_RD_LAT;
                        CMD_MRR: begin
                            state_d = ST_RD_LAT;
                            cnt_d   = CNT_W'(1);
                            is_mr_d = 1'b1;
                        end
                        CMD_INIT: begin
                            state_d = ST_INIT_CLR;
                            addr_d  = '0;
                        end
                        CMD_GRST: begin
                            mr_d    = MR_DEFAULTS;
                            state_d = ST_DONE;
                        end
                        default: begin
                            cmd_error_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (is_mr_q) begin
                    mr_d[addr_q[1:0]] = mask_merge(mr_q[addr_q[1:0]], bd_wdata, bd_wdata_mask);
                end else begin
                    mem_we_s = 1'b1;
                    mem_be_s = ~bd_wdata_mask;
                end
                addr_d = addr_q + ADDR_WIDTH'(1);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_LAT: begin
                // The last wait cycle issues the first read so data meets valid.
                if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
                    state_d = ST_RD_DATA;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    mr_rd_d = mr_q[addr_q[1:0]];
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_RD_DATA: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                mr_rd_d = mr_q[addr_q[1:0]];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_INIT_CLR: begin
                mem_we_s    = 1'b1;
                mem_be_s    = 2'b11;
                mem_wdata_s = 16'h0000;
                addr_d      = addr_q + ADDR_WIDTH'(1);
                if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_INIT_CLR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            is_mr_q     <= 1'b0;
            ready_q     <= 1'b0;
            cmd_error_q <= 1'b0;
            mr_q        <= MR_DEFAULTS;
            mr_rd_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            is_mr_q     <= is_mr_d;
            ready_q     <= ready_d;
            cmd_error_q <= cmd_error_d;
            mr_q        <= mr_d;
            mr_rd_q     <= mr_rd_d;
        end
    end

    assign bd_instruction_ready = ready_q;
    assign cmd_error            = cmd_error_q;
    assign bd_wdata_ready       = (state_q == ST_WR_DATA);
    assign bd_rdata_valid       = (state_q == ST_RD_DATA);
    assign busy                 = (state_q != ST_IDLE);
    assign bd_rdata             = bd_rdata_valid ? (is_mr_q ? mr_rd_q : mem_rdata_s) : 16'h0000;

endmodule
